run_controller: RTL and testbench
=================================

Name: run_controller

Overview:
Sequences the RISC processor between user-selected programs. Turns single-cycle button events into a program-copy phase, with the processor held in reset and program_selector driven. It then releases the processor, monitors the PC for a halt loop or watchdog expiry, and latches the result register value. It sits between the debounced buttons and the pc/regfile instances in the labkit top level.

Parameters:
COPY_CYCLES, 4, cycles program_selector is held with cpu_reset asserted, to allow the regfile copy
HALT_CYCLES, 3, consecutive cycles of an unchanged pc that declare a halt
WATCHDOG, 65535, maximum RUN cycles before timeout
CW, 32, cycle_count width

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
fib_act  input  1  one-cycle request: run program 1
sort_act  input  1  one-cycle request: run program 2
load_act  input  1  one-cycle request: run program 3
save_act  input  1  one-cycle request: snapshot reg_data into result
abort  input  1  level; forces return to IDLE
pc  input  32  processor PC
reg_data  input  32  processor output register
cpu_reset  output  1  active-high reset to pc/regfile/ctl
program_selector  output  32  program code to regfile
state  output  3  current FSM state encoding
busy  output  1  high in LOAD or RUN
done  output  1  high in DONE
timeout  output  1  high in TOUT
cycle_count  output  CW  RUN cycles elapsed, frozen after RUN
result  output  32  latched reg_data

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE, cpu_reset=1, program_selector=0, cycle_count=0, result=0, busy=done=timeout=0.
- States: IDLE=0, LOAD=1, RUN=2, DONE=3, TOUT=4. All outputs are registered.
- Request priority on the same cycle: fib > sort > load. The encoding is sel = 1/2/3.
- IDLE, DONE, TOUT: a request moves to LOAD next cycle. program_selector=sel, cpu_reset=1, copy counter=0, cycle_count=0, done/timeout clear. With no request the state holds; cpu_reset=1 in IDLE and stays 0 in DONE/TOUT so the CPU stays parked on its halt loop.
- LOAD: cpu_reset=1 and program_selector held. After exactly COPY_CYCLES cycles in LOAD → RUN. On the RUN entry edge program_selector returns to 0 and cpu_reset falls to 0. Requests in LOAD are ignored.
- RUN: cycle_count increments by 1 per cycle, saturating at all-ones. A halt counter increments when pc equals the previous-cycle pc and clears otherwise. When it reaches HALT_CYCLES → DONE, result<=reg_data on that edge. When cycle_count reaches WATCHDOG → TOUT, result unchanged. If both occur on the same cycle, DONE wins. Requests in RUN are ignored.
- save_act: in any state other than LOAD, result<=reg_data on the next edge. In LOAD it is ignored. It coincides harmlessly with a DONE capture, since both load the same value.
- abort (level, synchronous sampling) → IDLE next cycle from any state, with cpu_reset=1 and program_selector=0. abort beats every request.
- Previous-pc register resets to 0 and reloads every cycle. It is cleared on LOAD→RUN so the first RUN cycle never counts as a halt match.
- Async reset mid-LOAD/RUN returns immediately to the reset values; no partial state survives.

Decomposition:
- Shared package run_ctl_pkg: state encodings, program codes (PROG_NONE=0, PROG_FIB=1, PROG_SORT=2, PROG_LOAD=3).
- One natural sub-module: halt_detect, containing the pc compare register, the halt counter, and the halted output; its clear input is driven on RUN entry.
- FSM, watchdog and result latch stay in run_controller.

Test Plan:
- Reset then fib_act pulse at t0 → state=LOAD at t0+1, program_selector=1, cpu_reset=1 for 4 cycles. Then state=RUN, cpu_reset=0, program_selector=0.
- RUN with pc incrementing 0,4,8 then stuck at 0x20 → DONE exactly 3 cycles after the first repeat. result=reg_data (e.g. 0x00000037), cycle_count frozen.
- fib_act, sort_act and load_act on the same cycle from IDLE → program_selector=1. sort_act during RUN → no effect.
- WATCHDOG=16 with pc always incrementing → TOUT after 16 RUN cycles, timeout=1, result unchanged. Halt and watchdog on the same cycle → DONE.
- abort asserted in RUN → IDLE next cycle, cpu_reset=1. reset_n pulsed low mid-LOAD → all outputs at reset values before the next clock edge.
- save_act in DONE with reg_data=0xDEADBEEF → result=0xDEADBEEF next cycle. save_act in LOAD → result unchanged.

Source files
------------

// File: rtl/run_ctl_pkg.sv
// Shared encodings for the run controller: FSM states and regfile program codes.
package run_ctl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_DONE = 3'd3,
    ST_TOUT = 3'd4
  } state_t;

  localparam logic [31:0] PROG_NONE = 32'd0;
  localparam logic [31:0] PROG_FIB  = 32'd1;
  localparam logic [31:0] PROG_SORT = 32'd2;
  localparam logic [31:0] PROG_LOAD = 32'd3;

  // Same-cycle requests resolve fib > sort > load.
  function automatic logic [31:0] prog_select(input logic fib, input logic sort, input logic load);
    if (fib)       return PROG_FIB;
    else if (sort) return PROG_SORT;
    else if (load) return PROG_LOAD;
    else           return PROG_NONE;
  endfunction

endpackage

// File: rtl/halt_detect.sv
// Declares a halt once the PC has stayed put for HALT_CYCLES consecutive cycles.
module halt_detect #(
  parameter int unsigned HALT_CYCLES = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        en,
  input  logic        clear,
  input  logic [31:0] pc,
  output logic        halted
);

  localparam int unsigned HW = $clog2(HALT_CYCLES + 1);

  logic [31:0]   prev_pc;
  logic          prev_vld;
  logic [HW-1:0] halt_cnt;
  logic          match;

  // prev_vld keeps the first cycle after a clear from matching a stale or zero PC.
  assign match  = en && prev_vld && (pc == prev_pc);
  assign halted = match && (halt_cnt == HW'(HALT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_pc  <= '0;
      prev_vld <= 1'b0;
      halt_cnt <= '0;
    end else if (clear) begin
      prev_pc  <= '0;
      prev_vld <= 1'b0;
      halt_cnt <= '0;
    end else begin
      prev_pc  <= pc;
      prev_vld <= 1'b1;
      if (!match)
        halt_cnt <= '0;
      else if (halt_cnt != HW'(HALT_CYCLES))
        halt_cnt <= halt_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/run_controller.sv
// Sequences program copy, CPU release, halt/watchdog monitoring and result capture.
module run_controller
  import run_ctl_pkg::*;
#(
  parameter int unsigned COPY_CYCLES = 4,
  parameter int unsigned HALT_CYCLES = 3,
  parameter int unsigned WATCHDOG    = 65535,
  parameter int unsigned CW          = 32
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          fib_act,
  input  logic          sort_act,
  input  logic          load_act,
  input  logic          save_act,
  input  logic          abort,
  input  logic [31:0]   pc,
  input  logic [31:0]   reg_data,
  output logic          cpu_reset,
  output logic [31:0]   program_selector,
  output logic [2:0]    state,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] cycle_count,
  output logic [31:0]   result
);

  localparam int unsigned CPW = (COPY_CYCLES > 1) ? $clog2(COPY_CYCLES) : 1;

  state_t         state_q, state_d;
  logic [CPW-1:0] copy_q, copy_d;
  logic [CW-1:0]  cc_d;
  logic [31:0]    psel_d, res_d, sel;
  logic           cr_d, busy_d, done_d, tout_d;
  logic           run_en, run_clear, halted;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign sel    = prog_select(fib_act, sort_act, load_act);
  assign run_en = (state_q == ST_RUN);
  assign state  = state_q;

  halt_detect #(.HALT_CYCLES(HALT_CYCLES)) u_halt (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (run_en),
    .clear   (run_clear),
    .pc      (pc),
    .halted  (halted)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= ST_IDLE;
      copy_q           <= '0;
      cycle_count      <= '0;
      result           <= '0;
      program_selector <= PROG_NONE;
      cpu_reset        <= 1'b1;
      busy             <= 1'b0;
      done             <= 1'b0;
      timeout          <= 1'b0;
    end else begin
      state_q          <= state_d;
      copy_q           <= copy_d;
      cycle_count      <= cc_d;
      result           <= res_d;
      program_selector <= psel_d;
      cpu_reset        <= cr_d;
      busy             <= busy_d;
      done             <= done_d;
      timeout          <= tout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    copy_d    = copy_q;
    cc_d      = cycle_count;
    psel_d    = PROG_NONE;
    res_d     = result;
    run_clear = 1'b0;

    if (save_act && (state_q != ST_LOAD))
      res_d = reg_data;

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_TOUT: begin
          if (sel != PROG_NONE) begin
            state_d = ST_LOAD;
            psel_d  = sel;
            copy_d  = '0;
            cc_d    = '0;
          end
        end
        ST_LOAD: begin
          if (copy_q == CPW'(COPY_CYCLES - 1)) begin
            state_d   = ST_RUN;
            run_clear = 1'b1;
          end else begin
            copy_d = copy_q + 1'b1;
            psel_d = program_selector;
          end
        end
        ST_RUN: begin
          cc_d = sat_inc(cycle_count);
          // A halt detected on the watchdog's last cycle still reports DONE.
          if (halted) begin
            state_d = ST_DONE;
            res_d   = reg_data;
          end else if (cycle_count == CW'(WATCHDOG - 1)) begin
            state_d = ST_TOUT;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // CPU stays parked (not reset) in DONE/TOUT so it keeps spinning on its halt loop.
    cr_d   = (state_d == ST_IDLE) || (state_d == ST_LOAD);
    busy_d = (state_d == ST_LOAD) || (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
    tout_d = (state_d == ST_TOUT);
  end

endmodule

// File: tb/tb_run_controller.sv
// Scoreboard bench for run_controller: expected output snapshots are queued by stimulus, checked on every state/result change.
module tb_run_controller;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        fib_act = 1'b0, sort_act = 1'b0, load_act = 1'b0, save_act = 1'b0, abort = 1'b0;
  logic [31:0] pc = 32'd0;
  logic [31:0] reg_data = 32'd0;
  logic        cpu_reset;
  logic [31:0] program_selector;
  logic [2:0]  state;
  logic        busy, done, timeout;
  logic [31:0] cycle_count;
  logic [31:0] result;

  run_controller #(
    .COPY_CYCLES (4),
    .HALT_CYCLES (3),
    .WATCHDOG    (16),
    .CW          (32)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .fib_act          (fib_act),
    .sort_act         (sort_act),
    .load_act         (load_act),
    .save_act         (save_act),
    .abort            (abort),
    .pc               (pc),
    .reg_data         (reg_data),
    .cpu_reset        (cpu_reset),
    .program_selector (program_selector),
    .state            (state),
    .busy             (busy),
    .done             (done),
    .timeout          (timeout),
    .cycle_count      (cycle_count),
    .result           (result)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    int          cyc;
    logic [2:0]  st;
    logic        cr;
    logic [31:0] ps;
    logic        b;
    logic        d;
    logic        t;
    logic [31:0] cc;
    logic [31:0] res;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   applied = 0;
  int   miscompares = 0;
  bit   auto_pc = 1'b0;

  initial forever begin
    @(posedge clock);
    cyc = cyc + 1;
  end

  task automatic expect_out(input string name, input int c, input logic [2:0] st, input logic cr,
                            input logic [31:0] ps, input logic b, input logic d, input logic t,
                            input logic [31:0] cc, input logic [31:0] res);
    exp_t e;
    e.name = name; e.cyc = c; e.st = st; e.cr = cr; e.ps = ps;
    e.b = b; e.d = d; e.t = t; e.cc = cc; e.res = res;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (auto_pc) pc = pc + 32'd4;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      $display("FAIL %s: timed out at cyc=%0d, required output change at cyc=%0d", sb[0].name, cyc, sb[0].cyc);
      applied += sb.size();
      miscompares += sb.size();
      sb.delete();
    end
    repeat (3) tick();
  endtask

  initial begin : monitor
    logic [34:0] prev, cur;
    bit first;
    exp_t e;
    first = 1'b1;
    prev = '0;
    forever begin
      @(negedge clock);
      cur = {state, result};
      if (first || cur != prev) begin
        applied++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_change: got cyc=%0d state=%0d result=%h, required no change", cyc, state, result);
        end else begin
          e = sb.pop_front();
          if (cyc != e.cyc || state !== e.st || cpu_reset !== e.cr || program_selector !== e.ps ||
              busy !== e.b || done !== e.d || timeout !== e.t || cycle_count !== e.cc || result !== e.res) begin
            miscompares++;
            $display("FAIL %s: got cyc=%0d st=%0d rst=%0b sel=%0d busy=%0b done=%0b tout=%0b cc=%0d res=%h, required cyc=%0d st=%0d rst=%0b sel=%0d busy=%0b done=%0b tout=%0b cc=%0d res=%h",
                     e.name, cyc, state, cpu_reset, program_selector, busy, done, timeout, cycle_count, result,
                     e.cyc, e.st, e.cr, e.ps, e.b, e.d, e.t, e.cc, e.res);
          end
        end
      end
      prev = cur;
      first = 1'b0;
    end
  end

  initial begin : stimulus
    int k, m, n, p, q, r;

    expect_out("reset", 1, 3'd0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    reg_data = 32'h0000_0037;

    // fib run ending in a halt loop at 0x20; sort_act mid-run must be ignored
    k = cyc;
    expect_out("fib_load", k + 1,  3'd1, 1'b1, 32'd1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    expect_out("fib_run",  k + 5,  3'd2, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    expect_out("fib_done", k + 12, 3'd3, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd7, 32'h0000_0037);
    fib_act = 1'b1; tick(); fib_act = 1'b0;
    repeat (5) tick();
    pc = 32'd4; tick();
    pc = 32'd8; sort_act = 1'b1; tick();
    sort_act = 1'b0; pc = 32'h20;
    drain(40);

    // snapshot in DONE; cycle_count stays frozen
    m = cyc;
    reg_data = 32'hDEAD_BEEF;
    expect_out("save_done", m + 1, 3'd3, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd7, 32'hDEAD_BEEF);
    save_act = 1'b1; tick(); save_act = 1'b0;
    auto_pc = 1'b1;
    drain(10);

    // all three requests at once, save ignored in LOAD, abort in RUN
    m = cyc;
    expect_out("prio_load", m + 1, 3'd1, 1'b1, 32'd1, 1'b1, 1'b0, 1'b0, 32'd0, 32'hDEAD_BEEF);
    expect_out("prio_run",  m + 5, 3'd2, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'hDEAD_BEEF);
    expect_out("abort_run", m + 8, 3'd0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 32'd2, 32'hDEAD_BEEF);
    fib_act = 1'b1; sort_act = 1'b1; load_act = 1'b1; tick();
    fib_act = 1'b0; sort_act = 1'b0; load_act = 1'b0;
    reg_data = 32'h1111_1111; save_act = 1'b1; tick(); save_act = 1'b0;
    while (cyc < m + 7) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    drain(20);

    // watchdog expiry with a PC that never repeats
    n = cyc;
    reg_data = 32'hCAFE_0000;
    expect_out("sort_load", n + 1,  3'd1, 1'b1, 32'd2, 1'b1, 1'b0, 1'b0, 32'd0,  32'hDEAD_BEEF);
    expect_out("sort_run",  n + 5,  3'd2, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0,  32'hDEAD_BEEF);
    expect_out("wd_tout",   n + 21, 3'd4, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'd16, 32'hDEAD_BEEF);
    sort_act = 1'b1; tick(); sort_act = 1'b0;
    drain(40);

    // halt declared on the same edge the watchdog expires
    p = cyc;
    reg_data = 32'h5A5A_5A5A;
    expect_out("load_load", p + 1,  3'd1, 1'b1, 32'd3, 1'b1, 1'b0, 1'b0, 32'd0,  32'hDEAD_BEEF);
    expect_out("load_run",  p + 5,  3'd2, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0,  32'hDEAD_BEEF);
    expect_out("tie_done",  p + 21, 3'd3, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd16, 32'h5A5A_5A5A);
    load_act = 1'b1; tick(); load_act = 1'b0;
    while (cyc < p + 17) tick();
    auto_pc = 1'b0;
    drain(20);

    // asynchronous reset mid-LOAD
    q = cyc;
    auto_pc = 1'b1;
    expect_out("fib2_load",  q + 1, 3'd1, 1'b1, 32'd1, 1'b1, 1'b0, 1'b0, 32'd0, 32'h5A5A_5A5A);
    expect_out("async_rst",  q + 2, 3'd0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    fib_act = 1'b1; tick(); fib_act = 1'b0;
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    drain(10);

    // recovery after reset, then abort during LOAD
    r = cyc;
    expect_out("sort2_load", r + 1, 3'd1, 1'b1, 32'd2, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    expect_out("abort_load", r + 3, 3'd0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    sort_act = 1'b1; tick(); sort_act = 1'b0;
    tick();
    abort = 1'b1; tick(); abort = 1'b0;
    drain(10);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
